reorder_buffer: RTL and testbench

In-order commit buffer for the out-of-order core, sitting between issue/decode and the register file. Allocates a ROB id per issued instruction, captures results from the EX and LD CDBs, and answers the register file's operand lookups by ROB id. Retires the head entry once per cycle through the `ROB_cmt_*` port. A mispredicted branch at the head triggers a whole-machine flush via `jump_wrong_stall`.

---
 rtl/reorder_buffer.sv | 179 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates ROB ids, captures EX/LD CDB results, answers
// operand lookups by id, retires one head entry per cycle and flushes on a head mispredict.
module reorder_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ID_alloc_flag,
  input  logic [4:0]  ID_alloc_rd,
  input  logic        ID_alloc_is_br,
  input  logic        ID_alloc_ready,
  input  logic [31:0] ID_alloc_val,
  output logic        ROB_full,
  output logic [31:0] ROB_next_id,
  input  logic [31:0] rob_id1,
  input  logic [31:0] rob_id2,
  output logic        rob_id1_rdy,
  output logic        rob_id2_rdy,
  output logic [31:0] rob_id1_val,
  output logic [31:0] rob_id2_val,
  input  logic        ex_cdb_flag,
  input  logic [31:0] ex_cdb_rob_id,
  input  logic [31:0] ex_cdb_val,
  input  logic        ex_cdb_jump_wrong,
  input  logic [31:0] ex_cdb_jump_pc,
  input  logic        ld_cdb_flag,
  input  logic [31:0] ld_cdb_rob_id,
  input  logic [31:0] ld_cdb_val,
  output logic        ROB_cmt_flag,
  output logic [4:0]  ROB_cmt_rd,
  output logic [31:0] ROB_cmt_rob_id,
  output logic [31:0] ROB_cmt_val,
  output logic        jump_wrong_stall,
  output logic [31:0] jump_pc
);

  // state   | meaning
  // S_RUN   | normal operation: allocate, capture CDBs, commit
  // S_FLUSH | mispredicted branch committed; next edge clears the whole buffer
  typedef enum logic {S_RUN, S_FLUSH} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] r_valid, r_ready, r_is_br, r_jw;
  logic [4:0]       r_rd  [DEPTH];
  logic [31:0]      r_val [DEPTH];
  logic [31:0]      r_jpc [DEPTH];
  logic [AW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  state_t           r_state, w_state_nxt;

  logic        r_cmt_flag, r_stall;
  logic [4:0]  r_cmt_rd;
  logic [31:0] r_cmt_id, r_cmt_val, r_jump_pc;

  logic w_full, w_commit, w_alloc, w_cdb_en, w_flush_start, w_flush_clear;
  logic w_ex_hit, w_ld_hit;
  logic [AW-1:0] w_ex_slot, w_ld_slot, w_l1_slot, w_l2_slot;

  // ids are slot+1; the low bits of (id-1) select the slot
  assign w_ex_slot = AW'(ex_cdb_rob_id - 32'd1);
  assign w_ld_slot = AW'(ld_cdb_rob_id - 32'd1);
  assign w_l1_slot = AW'(rob_id1 - 32'd1);
  assign w_l2_slot = AW'(rob_id2 - 32'd1);

  assign w_full      = (r_count == CW'(DEPTH));
  assign ROB_full    = w_full;
  assign ROB_next_id = 32'(r_tail) + 32'd1;

  assign rob_id1_rdy = (rob_id1 != 32'd0) && r_ready[w_l1_slot];
  assign rob_id2_rdy = (rob_id2 != 32'd0) && r_ready[w_l2_slot];
  assign rob_id1_val = (rob_id1 != 32'd0) ? r_val[w_l1_slot] : 32'd0;
  assign rob_id2_val = (rob_id2 != 32'd0) ? r_val[w_l2_slot] : 32'd0;

  assign ROB_cmt_flag     = r_cmt_flag;
  assign ROB_cmt_rd       = r_cmt_rd;
  assign ROB_cmt_rob_id   = r_cmt_id;
  assign ROB_cmt_val      = r_cmt_val;
  assign jump_wrong_stall = r_stall;
  assign jump_pc          = r_jump_pc;

  always_comb begin
    w_state_nxt   = r_state;
    w_commit      = 1'b0;
    w_alloc       = 1'b0;
    w_cdb_en      = 1'b0;
    w_flush_start = 1'b0;
    w_flush_clear = 1'b0;
    case (r_state)
      S_RUN: begin
        // the stall cycle still blocks CDB capture and allocation
        w_cdb_en = !r_stall;
        w_alloc  = ID_alloc_flag && !w_full && !r_stall;
        w_commit = r_valid[r_head] && r_ready[r_head];
        if (w_commit && r_is_br[r_head] && r_jw[r_head]) begin
          w_flush_start = 1'b1;
          w_state_nxt   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_flush_clear = 1'b1;
        w_state_nxt   = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_ex_hit = w_cdb_en && ex_cdb_flag && (ex_cdb_rob_id != 32'd0) && r_valid[w_ex_slot];
  assign w_ld_hit = w_cdb_en && ld_cdb_flag && (ld_cdb_rob_id != 32'd0) && r_valid[w_ld_slot];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_RUN;
      r_valid    <= '0;
      r_ready    <= '0;
      r_is_br    <= '0;
      r_jw       <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_cmt_flag <= 1'b0;
      r_cmt_rd   <= '0;
      r_cmt_id   <= '0;
      r_cmt_val  <= '0;
      r_stall    <= 1'b0;
      r_jump_pc  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]  <= '0;
        r_val[i] <= '0;
        r_jpc[i] <= '0;
      end
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_cmt_flag <= w_commit;
      r_stall    <= w_flush_clear;
      if (w_commit) begin
        r_cmt_rd  <= r_rd[r_head];
        r_cmt_id  <= 32'(r_head) + 32'd1;
        r_cmt_val <= r_val[r_head];
      end
      if (w_flush_start)
        r_jump_pc <= r_jpc[r_head];
      if (w_flush_clear) begin
        r_valid <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_ex_hit) begin
          r_ready[w_ex_slot] <= 1'b1;
          r_val[w_ex_slot]   <= ex_cdb_val;
          r_jw[w_ex_slot]    <= ex_cdb_jump_wrong;
          r_jpc[w_ex_slot]   <= ex_cdb_jump_pc;
        end
        if (w_ld_hit) begin
          r_ready[w_ld_slot] <= 1'b1;
          r_val[w_ld_slot]   <= ld_cdb_val;
        end
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_ready[r_tail] <= ID_alloc_ready;
          r_val[r_tail]   <= ID_alloc_val;
          r_rd[r_tail]    <= ID_alloc_rd;
          r_is_br[r_tail] <= ID_alloc_is_br;
          r_jw[r_tail]    <= 1'b0;
          r_tail          <= r_tail + AW'(1);
        end
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + AW'(1);
        end
        r_count <= r_count + CW'(w_alloc) - CW'(w_commit);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a vector table, directed corner-case
// sequences, and randomized traffic against a queue-based reference model.
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ID_alloc_flag, ID_alloc_is_br, ID_alloc_ready;
  logic [4:0]  ID_alloc_rd;
  logic [31:0] ID_alloc_val;
  logic        ROB_full;
  logic [31:0] ROB_next_id;
  logic [31:0] rob_id1, rob_id2;
  logic        rob_id1_rdy, rob_id2_rdy;
  logic [31:0] rob_id1_val, rob_id2_val;
  logic        ex_cdb_flag, ex_cdb_jump_wrong;
  logic [31:0] ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump_pc;
  logic        ld_cdb_flag;
  logic [31:0] ld_cdb_rob_id, ld_cdb_val;
  logic        ROB_cmt_flag;
  logic [4:0]  ROB_cmt_rd;
  logic [31:0] ROB_cmt_rob_id, ROB_cmt_val;
  logic        jump_wrong_stall;
  logic [31:0] jump_pc;

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ID_alloc_flag(ID_alloc_flag), .ID_alloc_rd(ID_alloc_rd), .ID_alloc_is_br(ID_alloc_is_br),
    .ID_alloc_ready(ID_alloc_ready), .ID_alloc_val(ID_alloc_val),
    .ROB_full(ROB_full), .ROB_next_id(ROB_next_id),
    .rob_id1(rob_id1), .rob_id2(rob_id2),
    .rob_id1_rdy(rob_id1_rdy), .rob_id2_rdy(rob_id2_rdy),
    .rob_id1_val(rob_id1_val), .rob_id2_val(rob_id2_val),
    .ex_cdb_flag(ex_cdb_flag), .ex_cdb_rob_id(ex_cdb_rob_id), .ex_cdb_val(ex_cdb_val),
    .ex_cdb_jump_wrong(ex_cdb_jump_wrong), .ex_cdb_jump_pc(ex_cdb_jump_pc),
    .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id), .ld_cdb_val(ld_cdb_val),
    .ROB_cmt_flag(ROB_cmt_flag), .ROB_cmt_rd(ROB_cmt_rd), .ROB_cmt_rob_id(ROB_cmt_rob_id),
    .ROB_cmt_val(ROB_cmt_val), .jump_wrong_stall(jump_wrong_stall), .jump_pc(jump_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_alloc_flag = 0; ID_alloc_rd = 0; ID_alloc_is_br = 0; ID_alloc_ready = 0; ID_alloc_val = 0;
    rob_id1 = 0; rob_id2 = 0;
    ex_cdb_flag = 0; ex_cdb_rob_id = 0; ex_cdb_val = 0; ex_cdb_jump_wrong = 0; ex_cdb_jump_pc = 0;
    ld_cdb_flag = 0; ld_cdb_rob_id = 0; ld_cdb_val = 0;
  endtask

  task automatic do_reset();
    rst = 0; rdy = 1; idle();
    tick();
    rst = 1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic br, input logic ready, input logic [31:0] val);
    ID_alloc_flag = 1; ID_alloc_rd = rd; ID_alloc_is_br = br; ID_alloc_ready = ready; ID_alloc_val = val;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] alloc, rd, ardy, aval, ex_id, ex_val, ld_id, ld_val, l1, l2;
    logic [31:0] e_next, e_cf, e_crd, e_cid, e_cval, e_r1, e_v1, e_r2, e_v2;
  } vec_t;

  vec_t tv[9];

  // ---------------- reference model ----------------
  int          m_q[$];
  bit          m_valid[DEPTH+1], m_rdy[DEPTH+1], m_br[DEPTH+1], m_jw[DEPTH+1];
  logic [31:0] m_val[DEPTH+1], m_jpc[DEPTH+1];
  logic [4:0]  m_rd[DEPTH+1];
  int          m_next;
  bit          m_pend;
  bit          x_cf, x_stall;
  logic [4:0]  x_crd;
  logic [31:0] x_cid, x_cval, x_jpc;

  task automatic m_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      m_valid[i] = 0; m_rdy[i] = 0; m_br[i] = 0; m_jw[i] = 0;
      m_val[i] = 0; m_jpc[i] = 0; m_rd[i] = 0;
    end
    m_q.delete();
    m_next = 1; m_pend = 0;
    x_cf = 0; x_stall = 0; x_crd = 0; x_cid = 0; x_cval = 0; x_jpc = 0;
  endtask

  task automatic m_edge();
    bit commit, clear, alloc_ok, cdb_ok, flush;
    int h, id;
    if (!rst) begin
      m_reset();
      return;
    end
    if (!rdy) return;
    h = 0;
    clear    = m_pend;
    cdb_ok   = !m_pend && !x_stall;
    commit   = !m_pend && (m_q.size() > 0) && m_rdy[m_q[0]];
    alloc_ok = ID_alloc_flag && (m_q.size() < DEPTH) && !m_pend && !x_stall;
    flush    = 0;
    x_cf     = commit;
    x_stall  = clear;
    if (commit) begin
      h = m_q[0];
      x_crd = m_rd[h]; x_cid = h; x_cval = m_val[h];
      if (m_br[h] && m_jw[h]) begin
        flush = 1;
        x_jpc = m_jpc[h];
      end
    end
    if (clear) begin
      for (int i = 0; i <= DEPTH; i++) m_valid[i] = 0;
      m_q.delete();
      m_next = 1;
      m_pend = 0;
    end else begin
      id = int'(ex_cdb_rob_id);
      if (cdb_ok && ex_cdb_flag && id >= 1 && id <= DEPTH && m_valid[id]) begin
        m_rdy[id] = 1; m_val[id] = ex_cdb_val; m_jw[id] = ex_cdb_jump_wrong; m_jpc[id] = ex_cdb_jump_pc;
      end
      id = int'(ld_cdb_rob_id);
      if (cdb_ok && ld_cdb_flag && id >= 1 && id <= DEPTH && m_valid[id]) begin
        m_rdy[id] = 1; m_val[id] = ld_cdb_val;
      end
      if (alloc_ok) begin
        id = m_next;
        m_valid[id] = 1; m_rdy[id] = ID_alloc_ready; m_val[id] = ID_alloc_val;
        m_rd[id] = ID_alloc_rd; m_br[id] = ID_alloc_is_br; m_jw[id] = 0;
        m_q.push_back(id);
        m_next = (m_next % DEPTH) + 1;
      end
      if (commit) begin
        m_valid[h] = 0;
        void'(m_q.pop_front());
      end
      m_pend = flush;
    end
  endtask

  function automatic int pick_id();
    if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
      return m_q[$urandom_range(0, m_q.size() - 1)];
    return int'($urandom_range(0, DEPTH));
  endfunction

  initial begin
    // alloc rd ardy aval | ex_id ex_val ld_id ld_val | l1 l2 | next cf crd cid cval r1 v1 r2 v2
    tv[0] = '{1, 5, 1, 32'h11, 0, 0,       0, 0,       1, 0, 1, 0, 0, 0, 0,       0, 0,       0, 0};
    tv[1] = '{0, 0, 0, 0,      0, 0,       0, 0,       1, 0, 2, 0, 0, 0, 0,       1, 32'h11, 0, 0};
    tv[2] = '{1, 2, 0, 0,      0, 0,       0, 0,       1, 0, 2, 1, 5, 1, 32'h11, 1, 32'h11, 0, 0};
    tv[3] = '{1, 3, 0, 0,      0, 0,       0, 0,       2, 3, 3, 0, 0, 0, 0,       0, 0,       0, 0};
    tv[4] = '{0, 0, 0, 0,      3, 32'h33, 2, 32'h22, 2, 3, 4, 0, 0, 0, 0,       0, 0,       0, 0};
    tv[5] = '{0, 0, 0, 0,      0, 0,       0, 0,       2, 3, 4, 0, 0, 0, 0,       1, 32'h22, 1, 32'h33};
    tv[6] = '{0, 0, 0, 0,      0, 0,       0, 0,       2, 3, 4, 1, 2, 2, 32'h22, 1, 32'h22, 1, 32'h33};
    tv[7] = '{0, 0, 0, 0,      0, 0,       0, 0,       0, 3, 4, 1, 3, 3, 32'h33, 0, 0,       1, 32'h33};
    tv[8] = '{0, 0, 0, 0,      0, 0,       0, 0,       0, 2, 4, 0, 0, 0, 0,       0, 0,       1, 32'h22};

    // reset state
    do_reset();
    rob_id1 = 1;
    #1;
    chk1("rst_full", ROB_full, 1'b0);
    chk("rst_next_id", ROB_next_id, 32'd1);
    chk1("rst_cmt_flag", ROB_cmt_flag, 1'b0);
    chk1("rst_stall", jump_wrong_stall, 1'b0);
    chk("rst_jump_pc", jump_pc, 32'd0);
    chk1("rst_lookup_rdy", rob_id1_rdy, 1'b0);

    // table: alloc->commit latency, dual CDB capture, lookups, consecutive commits
    for (int i = 0; i < 9; i++) begin
      idle();
      ID_alloc_flag = tv[i].alloc[0]; ID_alloc_rd = tv[i].rd[4:0];
      ID_alloc_ready = tv[i].ardy[0]; ID_alloc_val = tv[i].aval;
      ex_cdb_flag = (tv[i].ex_id != 0); ex_cdb_rob_id = tv[i].ex_id; ex_cdb_val = tv[i].ex_val;
      ld_cdb_flag = (tv[i].ld_id != 0); ld_cdb_rob_id = tv[i].ld_id; ld_cdb_val = tv[i].ld_val;
      rob_id1 = tv[i].l1; rob_id2 = tv[i].l2;
      #1;
      chk($sformatf("tv%0d_next_id", i), ROB_next_id, tv[i].e_next);
      chk1($sformatf("tv%0d_full", i), ROB_full, 1'b0);
      chk1($sformatf("tv%0d_cmt_flag", i), ROB_cmt_flag, tv[i].e_cf[0]);
      if (tv[i].e_cf[0]) begin
        chk($sformatf("tv%0d_cmt_rd", i), 32'(ROB_cmt_rd), tv[i].e_crd);
        chk($sformatf("tv%0d_cmt_id", i), ROB_cmt_rob_id, tv[i].e_cid);
        chk($sformatf("tv%0d_cmt_val", i), ROB_cmt_val, tv[i].e_cval);
      end
      chk1($sformatf("tv%0d_id1_rdy", i), rob_id1_rdy, tv[i].e_r1[0]);
      chk($sformatf("tv%0d_id1_val", i), rob_id1_val, tv[i].e_v1);
      chk1($sformatf("tv%0d_id2_rdy", i), rob_id2_rdy, tv[i].e_r2[0]);
      chk($sformatf("tv%0d_id2_val", i), rob_id2_val, tv[i].e_v2);
      tick();
    end

    // fill to full, ignored 17th alloc, commit frees a slot, wrap to id 1
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc(5'(i + 1), 1'b0, 1'b0, 32'd0);
      #1 chk("fill_next_id", ROB_next_id, 32'(i + 1));
      tick();
    end
    #1;
    chk1("fill_full", ROB_full, 1'b1);
    chk("fill_next_wrap", ROB_next_id, 32'd1);
    tick();
    idle();
    #1;
    chk1("full_after_17th", ROB_full, 1'b1);
    chk("next_after_17th", ROB_next_id, 32'd1);
    chk1("no_commit_not_ready", ROB_cmt_flag, 1'b0);
    ex_cdb_flag = 1; ex_cdb_rob_id = 1; ex_cdb_val = 7;
    tick();
    idle();
    alloc(5'd9, 1'b0, 1'b0, 32'd0);
    rob_id1 = 1;
    #1;
    chk1("full_on_commit_cycle", ROB_full, 1'b1);
    chk1("full_lookup_rdy", rob_id1_rdy, 1'b1);
    chk("full_lookup_val", rob_id1_val, 32'd7);
    tick();
    ID_alloc_flag = 0;
    #1;
    chk1("full_cmt_flag", ROB_cmt_flag, 1'b1);
    chk("full_cmt_id", ROB_cmt_rob_id, 32'd1);
    chk("full_cmt_val", ROB_cmt_val, 32'd7);
    chk("full_cmt_rd", 32'(ROB_cmt_rd), 32'd1);
    chk1("full_drops", ROB_full, 1'b0);
    chk("full_alloc_ignored", ROB_next_id, 32'd1);
    alloc(5'd9, 1'b0, 1'b0, 32'd0);
    tick();
    ID_alloc_flag = 0;
    #1;
    chk("wrap_next_id", ROB_next_id, 32'd2);
    chk1("wrap_full_again", ROB_full, 1'b1);
    chk1("wrap_realloc_not_ready", rob_id1_rdy, 1'b0);

    // mispredict at head with younger entries pending
    do_reset();
    alloc(5'd1, 1'b1, 1'b0, 32'd0); tick();
    alloc(5'd2, 1'b0, 1'b0, 32'd0); tick();
    alloc(5'd3, 1'b0, 1'b1, 32'd5); tick();
    idle();
    ex_cdb_flag = 1; ex_cdb_rob_id = 1; ex_cdb_val = 32'h44;
    ex_cdb_jump_wrong = 1; ex_cdb_jump_pc = 32'h100;
    tick();
    idle();
    tick();
    alloc(5'd7, 1'b0, 1'b1, 32'd1);
    ex_cdb_flag = 1; ex_cdb_rob_id = 2; ex_cdb_val = 32'h77;
    #1;
    chk1("mp_cmt_flag", ROB_cmt_flag, 1'b1);
    chk("mp_cmt_rd", 32'(ROB_cmt_rd), 32'd1);
    chk("mp_cmt_id", ROB_cmt_rob_id, 32'd1);
    chk("mp_cmt_val", ROB_cmt_val, 32'h44);
    chk1("mp_no_stall_yet", jump_wrong_stall, 1'b0);
    tick();
    ex_cdb_flag = 0;
    #1;
    chk1("mp_stall", jump_wrong_stall, 1'b1);
    chk("mp_jump_pc", jump_pc, 32'h100);
    chk1("mp_stall_no_commit", ROB_cmt_flag, 1'b0);
    chk("mp_next_id", ROB_next_id, 32'd1);
    chk1("mp_full", ROB_full, 1'b0);
    tick();
    idle();
    rob_id1 = 2;
    #1;
    chk1("mp_stall_pulse_end", jump_wrong_stall, 1'b0);
    chk("mp_alloc_dropped", ROB_next_id, 32'd1);
    chk1("mp_cdb_ignored", rob_id1_rdy, 1'b0);
    alloc(5'd7, 1'b0, 1'b1, 32'h88);
    tick();
    idle();
    tick();
    #1;
    chk1("mp_post_cmt_flag", ROB_cmt_flag, 1'b1);
    chk("mp_post_cmt_id", ROB_cmt_rob_id, 32'd1);
    chk("mp_post_cmt_val", ROB_cmt_val, 32'h88);

    // rdy low holds a commit pulse and all state
    do_reset();
    alloc(5'd7, 1'b0, 1'b1, 32'h55); tick();
    alloc(5'd8, 1'b0, 1'b1, 32'h66); tick();
    rdy = 0;
    alloc(5'd9, 1'b0, 1'b1, 32'h99);
    #1;
    chk1("hold_pre_flag", ROB_cmt_flag, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("hold%0d_flag", k), ROB_cmt_flag, 1'b1);
      chk($sformatf("hold%0d_id", k), ROB_cmt_rob_id, 32'd1);
      chk($sformatf("hold%0d_val", k), ROB_cmt_val, 32'h55);
      chk($sformatf("hold%0d_next_id", k), ROB_next_id, 32'd3);
    end
    rdy = 1;
    idle();
    tick();
    chk1("resume_flag", ROB_cmt_flag, 1'b1);
    chk("resume_id", ROB_cmt_rob_id, 32'd2);
    chk("resume_val", ROB_cmt_val, 32'h66);
    chk("resume_rd", 32'(ROB_cmt_rd), 32'd8);
    tick();
    chk1("resume_single", ROB_cmt_flag, 1'b0);
    chk("resume_next_id", ROB_next_id, 32'd3);

    // reset right after a mispredict commit cancels the flush
    do_reset();
    alloc(5'd4, 1'b1, 1'b0, 32'd0); tick();
    idle();
    ex_cdb_flag = 1; ex_cdb_rob_id = 1; ex_cdb_val = 9;
    ex_cdb_jump_wrong = 1; ex_cdb_jump_pc = 32'h200;
    tick();
    idle();
    tick();
    chk1("rmf_commit", ROB_cmt_flag, 1'b1);
    rst = 0;
    tick();
    rst = 1;
    #1;
    chk1("rmf_flag", ROB_cmt_flag, 1'b0);
    chk("rmf_rd", 32'(ROB_cmt_rd), 32'd0);
    chk("rmf_id", ROB_cmt_rob_id, 32'd0);
    chk("rmf_val", ROB_cmt_val, 32'd0);
    chk1("rmf_stall", jump_wrong_stall, 1'b0);
    chk("rmf_jump_pc", jump_pc, 32'd0);
    chk1("rmf_full", ROB_full, 1'b0);
    chk("rmf_next_id", ROB_next_id, 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk1("rmf_no_stall", jump_wrong_stall, 1'b0);
    end

    // randomized traffic against the reference model
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int id1, id2;
      rdy = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 299) != 0);
      ID_alloc_flag = ($urandom_range(0, 9) < 6);
      ID_alloc_rd = 5'($urandom);
      ID_alloc_is_br = ($urandom_range(0, 3) == 0);
      ID_alloc_ready = ($urandom_range(0, 2) == 0);
      ID_alloc_val = $urandom;
      ex_cdb_flag = ($urandom_range(0, 9) < 5);
      ex_cdb_rob_id = 32'(pick_id());
      ex_cdb_val = $urandom;
      ex_cdb_jump_wrong = ($urandom_range(0, 5) == 0);
      ex_cdb_jump_pc = $urandom;
      ld_cdb_flag = ($urandom_range(0, 9) < 4);
      ld_cdb_rob_id = 32'(pick_id());
      ld_cdb_val = $urandom;
      if (ex_cdb_flag && ld_cdb_rob_id == ex_cdb_rob_id) ld_cdb_flag = 0;
      id1 = int'($urandom_range(0, DEPTH));
      id2 = int'($urandom_range(0, DEPTH));
      rob_id1 = 32'(id1);
      rob_id2 = 32'(id2);
      #1;
      chk1("rnd_full", ROB_full, m_q.size() == DEPTH);
      chk("rnd_next_id", ROB_next_id, 32'(m_next));
      chk1("rnd_cmt_flag", ROB_cmt_flag, x_cf);
      if (x_cf) begin
        chk("rnd_cmt_rd", 32'(ROB_cmt_rd), 32'(x_crd));
        chk("rnd_cmt_id", ROB_cmt_rob_id, x_cid);
        chk("rnd_cmt_val", ROB_cmt_val, x_cval);
      end
      chk1("rnd_stall", jump_wrong_stall, x_stall);
      chk("rnd_jump_pc", jump_pc, x_jpc);
      chk1("rnd_id1_rdy", rob_id1_rdy, (id1 == 0) ? 1'b0 : m_rdy[id1]);
      chk("rnd_id1_val", rob_id1_val, (id1 == 0) ? 32'd0 : m_val[id1]);
      chk1("rnd_id2_rdy", rob_id2_rdy, (id2 == 0) ? 1'b0 : m_rdy[id2]);
      chk("rnd_id2_val", rob_id2_val, (id2 == 0) ? 32'd0 : m_val[id2]);
      m_edge();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
